lavatory_occupancy_ctrl: RTL and testbench

- Parametrised successor to the single-cycle lavatory availability logic.
- Supports N lavatories with a per-lavatory male-permission mask.
- Adds input synchronisation, lock-switch debouncing and per-lavatory overstay timers with a latched, acknowledgeable alarm.
- Sits between the raw lock switches (SWI) and the LED/LCD status outputs in top.

---
 rtl/lavatory_occupancy_ctrl.sv | 132 +++++++++++++
 tb/tb_lavatory_occupancy_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/lavatory_occupancy_ctrl.sv
// Lavatory occupancy controller: synchronises and debounces N lock switches, derives
// availability outputs and runs a per-lavatory overstay timer with acknowledgeable alarm.
module lavatory_occupancy_ctrl #(
  parameter int                 N_LAV      = 3,
  parameter logic [N_LAV-1:0]   MALE_MASK  = 3'b110,
  parameter int                 DEB_CYCLES = 4,
  parameter int                 TIMEOUT    = 1000,
  parameter int                 TW         = $clog2(TIMEOUT + 1)
) (
  input  logic                         clk_2,
  input  logic                         reset_n,
  input  logic [N_LAV-1:0]             lock_raw,
  input  logic                         alarm_ack,
  output logic [N_LAV-1:0]             lock_db,
  output logic                         female_free,
  output logic                         male_free,
  output logic [$clog2(N_LAV+1)-1:0]   n_free,
  output logic [N_LAV-1:0]             overstay,
  output logic                         alarm
);

  localparam int NW = $clog2(N_LAV + 1);
  localparam int DW = $clog2(DEB_CYCLES + 1);

  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
  localparam logic [TW-1:0] T_MAX    = TW'(TIMEOUT);
  localparam logic [TW-1:0] T_LAST   = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_FREE,
    ST_OCC,
    ST_OVER
  } state_t;

  function automatic logic [TW-1:0] timer_sat_inc(input logic [TW-1:0] t);
    if (t >= T_MAX) return T_MAX;
    return t + TW'(1);
  endfunction

  function automatic logic [NW-1:0] count_ones(input logic [N_LAV-1:0] v);
    logic [NW-1:0] c;
    c = '0;
    for (int k = 0; k < N_LAV; k++) c = c + NW'(v[k]);
    return c;
  endfunction

  for (genvar i = 0; i < N_LAV; i++) begin : g_ch
    logic          sync_p0;
    logic          lock_s;
    logic [DW-1:0] deb_cnt;
    logic          db;
    state_t        state, state_nx;
    logic [TW-1:0] timer, timer_nx;

    // p0/p1: two-flop synchroniser, then debounce and timer state
    always_ff @(posedge clk_2 or negedge reset_n) begin
      if (!reset_n) begin
        sync_p0 <= 1'b0;
        lock_s  <= 1'b0;
        deb_cnt <= '0;
        db      <= 1'b0;
        state   <= ST_FREE;
        timer   <= '0;
      end else begin
        sync_p0 <= lock_raw[i];
        lock_s  <= sync_p0;
        if (lock_s == db) begin
          deb_cnt <= '0;
        end else if (deb_cnt == DEB_LAST) begin
          db      <= ~db;
          deb_cnt <= '0;
        end else begin
          deb_cnt <= deb_cnt + DW'(1);
        end
        state <= state_nx;
        timer <= timer_nx;
      end
    end

    // The overstay transition fires on the cycle the timer would reach TIMEOUT,
    // so the flag appears exactly TIMEOUT cycles after the debounced lock rises.
    always_comb begin
      state_nx = state;
      timer_nx = timer;
      case (state)
        ST_FREE: begin
          timer_nx = '0;
          if (db) begin
            state_nx = ST_OCC;
            timer_nx = TW'(1);
          end
        end
        ST_OCC: begin
          if (!db) begin
            state_nx = ST_FREE;
            timer_nx = '0;
          end else if (timer == T_LAST) begin
            state_nx = ST_OVER;
            timer_nx = T_MAX;
          end else begin
            timer_nx = timer_sat_inc(timer);
          end
        end
        ST_OVER: begin
          timer_nx = T_MAX;
          if (alarm_ack) begin
            if (db) begin
              state_nx = ST_OCC;
              timer_nx = TW'(1);
            end else begin
              state_nx = ST_FREE;
              timer_nx = '0;
            end
          end
        end
        default: begin
          state_nx = ST_FREE;
          timer_nx = '0;
        end
      endcase
    end

    assign lock_db[i]  = db;
    assign overstay[i] = (state == ST_OVER);
  end

  assign female_free = |(~lock_db);
  assign male_free   = |(~lock_db & MALE_MASK);
  assign n_free      = count_ones(~lock_db);
  assign alarm       = |overstay;

endmodule

// File: tb/tb_lavatory_occupancy_ctrl.sv
// Directed bench for lavatory_occupancy_ctrl (N_LAV=3, DEB_CYCLES=4, TIMEOUT=20).
module tb_lavatory_occupancy_ctrl;

  logic       clk_2;
  logic       reset_n;
  logic [2:0] lock_raw;
  logic       alarm_ack;
  logic [2:0] lock_db;
  logic       female_free;
  logic       male_free;
  logic [1:0] n_free;
  logic [2:0] overstay;
  logic       alarm;

  int checks = 0;
  int errors = 0;

  lavatory_occupancy_ctrl #(
    .N_LAV     (3),
    .MALE_MASK (3'b110),
    .DEB_CYCLES(4),
    .TIMEOUT   (20)
  ) dut (
    .clk_2      (clk_2),
    .reset_n    (reset_n),
    .lock_raw   (lock_raw),
    .alarm_ack  (alarm_ack),
    .lock_db    (lock_db),
    .female_free(female_free),
    .male_free  (male_free),
    .n_free     (n_free),
    .overstay   (overstay),
    .alarm      (alarm)
  );

  initial clk_2 = 1'b0;
  always #5 clk_2 = ~clk_2;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_2);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick(2);
    reset_n = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_lock_db"}, 32'(lock_db), 32'h0);
    check({tag, "_n_free"}, 32'(n_free), 32'd3);
    check({tag, "_female"}, 32'(female_free), 32'd1);
    check({tag, "_male"}, 32'(male_free), 32'd1);
    check({tag, "_alarm"}, 32'(alarm), 32'd0);
    check({tag, "_overstay"}, 32'(overstay), 32'h0);
  endtask

  initial begin
    reset_n   = 1'b0;
    lock_raw  = 3'b111;
    alarm_ack = 1'b0;

    // Reset with all locks closed, then release
    tick(2);
    check_reset_outputs("rst");
    reset_n = 1'b1;
    tick(5);
    check("rel_lock_db_c5", 32'(lock_db), 32'h0);
    tick(1);
    check("rel_lock_db_c6", 32'(lock_db), 32'h7);
    check("rel_n_free", 32'(n_free), 32'd0);
    check("rel_female", 32'(female_free), 32'd0);
    check("rel_male", 32'(male_free), 32'd0);

    // Glitch rejection on channel 1
    lock_raw = 3'b000;
    do_reset();
    lock_raw = 3'b010;
    tick(3);
    check("glitch_c3", 32'(lock_db), 32'h0);
    lock_raw = 3'b000;
    for (int k = 0; k < 8; k++) begin
      tick(1);
      check("glitch_hold", 32'(lock_db), 32'h0);
    end
    lock_raw = 3'b010;
    tick(5);
    check("clean_c5", 32'(lock_db), 32'h0);
    tick(1);
    check("clean_c6", 32'(lock_db), 32'h2);

    // Gender mask
    lock_raw = 3'b110;
    tick(6);
    check("m110_female", 32'(female_free), 32'd1);
    check("m110_male", 32'(male_free), 32'd0);
    check("m110_n_free", 32'(n_free), 32'd1);
    lock_raw = 3'b101;
    tick(6);
    check("m101_male", 32'(male_free), 32'd1);
    check("m101_n_free", 32'(n_free), 32'd1);
    lock_raw = 3'b111;
    tick(6);
    check("m111_female", 32'(female_free), 32'd0);
    check("m111_male", 32'(male_free), 32'd0);
    lock_raw = 3'b011;
    tick(6);
    check("m011_male", 32'(male_free), 32'd1);
    check("m011_n_free", 32'(n_free), 32'd1);
    lock_raw = 3'b000;
    tick(6);
    check("m000_n_free", 32'(n_free), 32'd3);

    // Overstay, unlock keeps it latched, ack clears
    do_reset();
    lock_raw = 3'b100;
    tick(6);
    check("ov_lock_db", 32'(lock_db), 32'h4);
    tick(19);
    check("ov_t19", 32'(overstay), 32'h0);
    tick(1);
    check("ov_t20", 32'(overstay), 32'h4);
    check("ov_alarm", 32'(alarm), 32'd1);
    lock_raw = 3'b000;
    tick(6);
    check("ov_unlocked_db", 32'(lock_db), 32'h0);
    check("ov_latched", 32'(overstay), 32'h4);
    alarm_ack = 1'b1;
    tick(1);
    alarm_ack = 1'b0;
    check("ov_acked", 32'(overstay), 32'h0);
    check("ov_acked_alarm", 32'(alarm), 32'd0);
    tick(25);
    check("ov_stays_clear", 32'(overstay), 32'h0);

    // Snooze with lock held
    lock_raw = 3'b100;
    tick(26);
    check("sn_fire", 32'(overstay), 32'h4);
    alarm_ack = 1'b1;
    tick(1);
    alarm_ack = 1'b0;
    check("sn_clear", 32'(overstay), 32'h0);
    tick(18);
    check("sn_a19", 32'(overstay), 32'h0);
    tick(1);
    check("sn_a20", 32'(overstay), 32'h4);

    // Ack on the same cycle the flag sets is ignored
    alarm_ack = 1'b1;
    tick(1);
    alarm_ack = 1'b0;
    tick(18);
    check("co_pre", 32'(overstay), 32'h0);
    alarm_ack = 1'b1;
    tick(1);
    alarm_ack = 1'b0;
    check("co_set_wins", 32'(overstay), 32'h4);
    tick(1);
    check("co_still_set", 32'(overstay), 32'h4);

    // One ack clears every channel in overstay
    do_reset();
    lock_raw = 3'b101;
    tick(26);
    check("multi_fire", 32'(overstay), 32'h5);
    alarm_ack = 1'b1;
    tick(1);
    alarm_ack = 1'b0;
    check("multi_ack", 32'(overstay), 32'h0);

    // Asynchronous reset mid-occupancy
    do_reset();
    lock_raw = 3'b100;
    tick(6);
    tick(15);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("mid");
    tick(2);
    reset_n = 1'b1;
    tick(5);
    check("mid_db_c5", 32'(lock_db), 32'h0);
    tick(1);
    check("mid_db_c6", 32'(lock_db), 32'h4);
    tick(19);
    check("mid_ov_c25", 32'(overstay), 32'h0);
    tick(1);
    check("mid_ov_c26", 32'(overstay), 32'h4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
